apb_slave_mem: RTL



---
 rtl/apb_slave_mem_if.sv | 29 ++
 rtl/apb_slave_mem.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between the requester and the memory completer
//
// Purpose: groups the APB handshake, address and data signals. The master modport
//          drives the request side, and the slave modport drives the response side.
// Signals: p_sel, p_en, p_write, addr[AWIDTH], wdata[DWIDTH]  (master -> slave)
//          rdata[DWIDTH], p_ready, p_slverr                     (slave -> master)
interface apb_slave_mem_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
);
    logic              p_sel;
    logic              p_en;
    logic              p_write;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rdata;
    logic              p_ready;
    logic              p_slverr;

    modport master (
        output p_sel, p_en, p_write, addr, wdata,
        input  rdata, p_ready, p_slverr
    );

    modport slave (
        input  p_sel, p_en, p_write, addr, wdata,
        output rdata, p_ready, p_slverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with word memory, wait-state config register and error response
//
// Purpose: decodes word addresses into a DEPTH-word memory and a 4-bit wait-state
//          register at CFG_ADDR. It inserts wait_cfg wait states before p_ready and
//          flags unmapped addresses with p_slverr. All outputs are registered.
// Ports:   clk  - bus clock, rising edge
//          rst  - asynchronous active-low reset (memory contents are retained)
//          bus  - apb_slave_mem_if.slave (p_sel/p_en/p_write/addr/wdata in,
//                 rdata/p_ready/p_slverr out)
module apb_slave_mem #(
    parameter int                AWIDTH   = 8,
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [AWIDTH-1:0] CFG_ADDR = AWIDTH'(8'hFF)
) (
    input  logic              clk,
    input  logic              rst,
    apb_slave_mem_if.slave    bus
);
    localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        wait_cfg_q, wait_cfg_d;
    logic              ready_q, ready_d;
    logic              slverr_q, slverr_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              mem_we;

    logic [DWIDTH-1:0] mem [DEPTH];

    // The setup edge decodes the live bus address, because the zero-wait case
    // must load rdata in the same edge. Later edges use the captured copy.
    logic [AWIDTH-1:0] dec_addr;
    logic              dec_write;
    logic              dec_mem;
    logic              dec_cfg;
    logic [DWIDTH-1:0] dec_rdata;

    always_comb begin
        dec_addr  = (state_q == IDLE) ? bus.addr : addr_q;
        dec_write = (state_q == IDLE) ? bus.p_write : write_q;
        dec_mem   = (dec_addr < DEPTH_A);
        dec_cfg   = (dec_addr == CFG_ADDR);
        dec_rdata = '0;
        if (!dec_write) begin
            if (dec_mem) begin
                dec_rdata = mem[dec_addr[IW-1:0]];
            end else if (dec_cfg) begin
                dec_rdata = DWIDTH'(wait_cfg_q);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_cfg_d = wait_cfg_q;
        ready_d    = ready_q;
        slverr_d   = slverr_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.p_sel && !bus.p_en) begin
                    addr_d  = bus.addr;
                    write_d = bus.p_write;
                    wdata_d = bus.wdata;
                    cnt_d   = wait_cfg_q;
                    state_d = ACCESS;
                    if (wait_cfg_q == 4'd0) begin
                        ready_d  = 1'b1;
                        slverr_d = !(dec_mem || dec_cfg);
                        rdata_d  = dec_rdata;
                    end
                end
            end

            ACCESS: begin
                if (!(bus.p_sel && bus.p_en)) begin
                    // The master dropped the transfer. Nothing is committed.
                    state_d  = IDLE;
                    cnt_d    = 4'd0;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                end else if (ready_q) begin
                    if (write_q) begin
                        if (dec_mem) begin
                            mem_we = 1'b1;
                        end else if (dec_cfg) begin
                            wait_cfg_d = wdata_q[3:0];
                        end
                    end
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                end else begin
                    // This state is reached with ready low only when cnt_q >= 1.
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        ready_d  = 1'b1;
                        slverr_d = !(dec_mem || dec_cfg);
                        rdata_d  = dec_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wait_cfg_q <= 4'd0;
            ready_q    <= 1'b0;
            slverr_q   <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cfg_q <= wait_cfg_d;
            ready_q    <= ready_d;
            slverr_q   <= slverr_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
        end
    end

    // The memory has no reset, so its contents survive rst. mem_we can only be
    // high in ACCESS, and ACCESS is forced away asynchronously by rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[IW-1:0]] <= wdata_q;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.p_ready  = ready_q;
    assign bus.p_slverr = slverr_q;
endmodule
